out_uart_tx: RTL

Output-port serializer that sits directly downstream of the `risc` core's 16-bit `out` port. Each word the core writes to `out` is captured into a small FIFO and transmitted over a UART 8N1 line as two bytes, high byte first. The core never stalls on output, so words arriving while the FIFO is full are dropped and flagged. The block lets the CPU's results be observed on a board pin instead of only in simulation.

---
 rtl/out_uart_pkg.sv | 11 +
 rtl/out_fifo.sv | 37 +++
 rtl/out_uart_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/out_uart_pkg.sv
// out_uart_pkg: shared FSM states, line levels and byte-order helper for the out-port UART.
package out_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam logic UART_IDLE = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP = 1'b1;
  localparam logic HIGH_BYTE_FIRST = 1'b1;
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic second);
    return (second ^ HIGH_BYTE_FIRST) ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/out_fifo.sv
// out_fifo: synchronous power-of-2 FIFO with registered count and active-low sync reset.
module out_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic wr, rd;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign wr = push_i & ~full_o;
  assign rd = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(rd);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wptr_q] <= wdata_i;
endmodule

// File: rtl/out_uart_tx.sv
// out_uart_tx: buffers 16-bit out-port words and sends each as two 8N1 bytes, high byte first.
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] out_data,
  input  logic        out_valid,
  output logic        out_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  tx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d;
  logic byte_q, byte_d;
  logic [15:0] shift_q, shift_d;
  logic tx_q, tx_d, ovf_q;
  logic full, empty, pop, bit_end;
  logic [15:0] head;
  logic [7:0] cur_byte;
  out_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(out_valid),
    .pop_i(pop),
    .wdata_i(out_data),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  assign out_ready = ~full;
  assign busy = ~empty | (state_q != IDLE);
  assign overflow = ovf_q;
  assign tx = tx_q;
  assign bit_end = timer_q == TW'(CLKS_PER_BIT - 1);
  assign cur_byte = pick_byte(shift_q, byte_q);
  // tx is registered from the current state, so the line lags the FSM by one cycle
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    byte_d = byte_q;
    shift_d = shift_q;
    pop = 1'b0;
    timer_d = (state_q == IDLE || bit_end) ? '0 : timer_q + 1'b1;
    tx_d = state_q == START ? UART_START : state_q == DATA ? cur_byte[bit_q] :
           state_q == STOP ? UART_STOP : UART_IDLE;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_d = head;
        byte_d = 1'b0;
        state_d = START;
      end
      START: if (bit_end) begin
        bit_d = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        byte_d = ~byte_q;
        state_d = byte_q ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q <= '0;
      byte_q <= 1'b0;
      shift_q <= '0;
      tx_q <= UART_IDLE;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ovf_q <= ovf_q | (out_valid & full);
    end
  end
endmodule
